// File: rtl/jk_ff_checker.sv
// jk_ff_checker
// Cycle-accurate response monitor for a JK flip-flop. It snoops the J/K
// stimulus together with the flop's Q/Q_BAR on the same clock and keeps its
// own prediction of Q. Any divergence between the flop and that prediction
// is flagged, and the monitor counts errors and predicted Q transitions.
// The block is purely observational and never drives the flop.
//
// Timing model: Q sampled at edge n+1 is the flop's response to the J/K
// sampled at edge n. The prediction made at edge n is therefore compared
// at edge n+1, which gives a check latency of one edge.
module jk_ff_checker #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             CLR,
  input  logic             J,
  input  logic             K,
  input  logic             Q,
  input  logic             Q_BAR,
  output logic             SYNCED,
  output logic             EXP_Q,
  output logic             MISMATCH,
  output logic             ERR_STICKY,
  output logic [CNT_W-1:0] ERR_COUNT,
  output logic [CNT_W-1:0] TRANS_COUNT
);

  // UNSYNC: the flop value is unknown. SYNC: exp_q_q tracks the flop.
  typedef enum logic [0:0] {
    ST_UNSYNC = 1'b0,
    ST_SYNC   = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // JK update applied to a known base value (SYNC state).
  function automatic logic jk_apply(input logic j, input logic k, input logic base);
    logic res;
    res = base;
    case ({j, k})
      2'b00:   res = base;
      2'b01:   res = 1'b0;
      2'b10:   res = 1'b1;
      2'b11:   res = ~base;
      default: res = base;
    endcase
    return res;
  endfunction

  // True when J/K force a definite value regardless of the previous state,
  // which is the only way to learn the flop value from UNSYNC.
  function automatic logic jk_is_load(input logic j, input logic k);
    return (j ^ k);
  endfunction

  // Saturating increment: an error counter must never wrap back to a low value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] res;
    if (val == CNT_MAX) begin
      res = val;
    end else begin
      res = val + CNT_ONE;
    end
    return res;
  endfunction

  // Registered state
  state_e           state_q,       state_d;
  logic             exp_q_q,       exp_q_d;
  logic             mismatch_q,    mismatch_d;
  logic             err_sticky_q,  err_sticky_d;
  logic [CNT_W-1:0] err_count_q,   err_count_d;
  logic [CNT_W-1:0] trans_count_q, trans_count_d;

  // Compare-phase terms
  logic comp_fault_s;
  logic val_fault_s;
  logic fault_s;
  logic base_s;

  // Compare phase: evaluate both fault kinds against the state before the edge.
  always_comb begin
    comp_fault_s = (Q_BAR == Q);
    val_fault_s  = (state_q == ST_SYNC) && (Q != exp_q_q);
    fault_s      = comp_fault_s || val_fault_s;
    // Re-align to the observed Q after a value fault so one stuck event
    // is reported once instead of on every following edge.
    if (val_fault_s) begin
      base_s = Q;
    end else begin
      base_s = exp_q_q;
    end
  end

  // Update phase: next prediction, state, pulse, sticky flag and counters.
  always_comb begin
    state_d       = state_q;
    exp_q_d       = exp_q_q;
    mismatch_d    = 1'b0;
    err_sticky_d  = err_sticky_q;
    err_count_d   = err_count_q;
    trans_count_d = trans_count_q;

    if (EN) begin
      mismatch_d = fault_s;

      if (fault_s) begin
        err_sticky_d = 1'b1;
        err_count_d  = sat_inc(err_count_q);
      end else begin
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
      end

      case (state_q)
        ST_UNSYNC: begin
          // Only 01/10 reveal the flop value; 00/11 depend on an unknown state.
          if (jk_is_load(J, K)) begin
            exp_q_d = J;
            state_d = ST_SYNC;
          end else begin
            exp_q_d = exp_q_q;
            state_d = ST_UNSYNC;
          end
        end
        ST_SYNC: begin
          exp_q_d = jk_apply(J, K, base_s);
          state_d = ST_SYNC;
          // The UNSYNC->SYNC load is not a transition; only SYNC changes count.
          if (exp_q_d != exp_q_q) begin
            trans_count_d = trans_count_q + CNT_ONE;
          end else begin
            trans_count_d = trans_count_q;
          end
        end
        default: begin
          exp_q_d = exp_q_q;
          state_d = ST_UNSYNC;
        end
      endcase
    end else begin
      // The flop keeps clocking while unobserved, so the prediction is stale.
      mismatch_d = 1'b0;
      state_d    = ST_UNSYNC;
    end

    // Clear wins over any increment or set at the same edge; the pulse,
    // state and prediction are unaffected.
    if (CLR) begin
      err_sticky_d  = 1'b0;
      err_count_d   = CNT_ZERO;
      trans_count_d = CNT_ZERO;
    end else begin
      err_sticky_d  = err_sticky_d;
      err_count_d   = err_count_d;
      trans_count_d = trans_count_d;
    end
  end

  // State and output registers, cleared asynchronously by RST_N.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_UNSYNC;
      exp_q_q       <= 1'b0;
      mismatch_q    <= 1'b0;
      err_sticky_q  <= 1'b0;
      err_count_q   <= CNT_ZERO;
      trans_count_q <= CNT_ZERO;
    end else begin
      state_q       <= state_d;
      exp_q_q       <= exp_q_d;
      mismatch_q    <= mismatch_d;
      err_sticky_q  <= err_sticky_d;
      err_count_q   <= err_count_d;
      trans_count_q <= trans_count_d;
    end
  end

  // Outputs come straight from registers; no input reaches an output combinationally.
  assign SYNCED      = (state_q == ST_SYNC);
  assign EXP_Q       = exp_q_q;
  assign MISMATCH    = mismatch_q;
  assign ERR_STICKY  = err_sticky_q;
  assign ERR_COUNT   = err_count_q;
  assign TRANS_COUNT = trans_count_q;

endmodule

// File: tb/tb_jk_ff_checker.sv
// Self-checking bench for jk_ff_checker. Two instances (CNT_W=8 and CNT_W=2)
// see identical stimulus; a behavioural reference model kept here predicts
// every output after each edge.
module tb_jk_ff_checker;

  logic CLK = 1'b0;
  logic RST_N, EN, CLR, J, K, Q, Q_BAR;

  logic       synced8, expq8, mis8, sticky8;
  logic [7:0] err8, trans8;
  logic       synced2, expq2, mis2, sticky2;
  logic [1:0] err2, trans2;

  jk_ff_checker #(.CNT_W(8)) dut8 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR(CLR), .J(J), .K(K), .Q(Q), .Q_BAR(Q_BAR),
    .SYNCED(synced8), .EXP_Q(expq8), .MISMATCH(mis8), .ERR_STICKY(sticky8),
    .ERR_COUNT(err8), .TRANS_COUNT(trans8)
  );

  jk_ff_checker #(.CNT_W(2)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR(CLR), .J(J), .K(K), .Q(Q), .Q_BAR(Q_BAR),
    .SYNCED(synced2), .EXP_Q(expq2), .MISMATCH(mis2), .ERR_STICKY(sticky2),
    .ERR_COUNT(err2), .TRANS_COUNT(trans2)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain variables, unbounded counters since last clear.
  bit m_synced;
  bit m_exp;
  bit m_mis;
  bit m_sticky;
  int m_err;
  int m_trans;

  // The bench's own idea of what a correct flop holds.
  bit flop_q = 1'b0;

  function automatic bit jk_flop(input bit cur, input bit j, input bit k);
    if (j && !k) return 1'b1;
    if (!j && k) return 1'b0;
    if (j && k)  return !cur;
    return cur;
  endfunction

  task automatic model_reset();
    m_synced = 0; m_exp = 0; m_mis = 0; m_sticky = 0; m_err = 0; m_trans = 0;
  endtask

  task automatic model_edge(input bit en, input bit clr, input bit j, input bit k,
                            input bit q, input bit qb);
    bit fault_val, base, nxt;
    if (en) begin
      fault_val = m_synced && (q != m_exp);
      m_mis     = (q == qb) || fault_val;
      base      = fault_val ? q : m_exp;
      if (j != k)      nxt = j;
      else if (m_synced) nxt = (j ? !base : base);
      else             nxt = m_exp;
      if (m_synced && (nxt != m_exp)) m_trans++;
      if (j != k) m_synced = 1;
      m_exp = nxt;
      if (m_mis) begin m_err++; m_sticky = 1; end
    end else begin
      m_mis = 0;
      m_synced = 0;
    end
    if (clr) begin m_sticky = 0; m_err = 0; m_trans = 0; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int e8, e2;
    e8 = (m_err > 255) ? 255 : m_err;
    e2 = (m_err > 3) ? 3 : m_err;
    chk("synced8", 32'(synced8), 32'(m_synced));
    chk("expq8",   32'(expq8),   32'(m_exp));
    chk("mis8",    32'(mis8),    32'(m_mis));
    chk("sticky8", 32'(sticky8), 32'(m_sticky));
    chk("err8",    32'(err8),    32'(e8));
    chk("trans8",  32'(trans8),  32'(m_trans % 256));
    chk("synced2", 32'(synced2), 32'(m_synced));
    chk("expq2",   32'(expq2),   32'(m_exp));
    chk("mis2",    32'(mis2),    32'(m_mis));
    chk("sticky2", 32'(sticky2), 32'(m_sticky));
    chk("err2",    32'(err2),    32'(e2));
    chk("trans2",  32'(trans2),  32'(m_trans % 4));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_synced"}, 32'(synced8), 32'd0);
    chk({tag, "_expq"},   32'(expq8),   32'd0);
    chk({tag, "_mis"},    32'(mis8),    32'd0);
    chk({tag, "_sticky"}, 32'(sticky8), 32'd0);
    chk({tag, "_err"},    32'(err8),    32'd0);
    chk({tag, "_trans"},  32'(trans8),  32'd0);
    chk({tag, "_err2"},   32'(err2),    32'd0);
  endtask

  // One enabled/disabled edge with explicit Q/Q_BAR; called at a negedge.
  task automatic step(input bit en, input bit clr, input bit j, input bit k,
                      input bit q, input bit qb);
    EN = en; CLR = clr; J = j; K = k; Q = q; Q_BAR = qb;
    @(posedge CLK);
    model_edge(en, clr, j, k, q, qb);
    flop_q = jk_flop(flop_q, j, k);
    @(negedge CLK);
    n_vec++;
    check_all();
  endtask

  // Edge with a correctly behaving flop.
  task automatic good(input bit en, input bit clr, input bit j, input bit k);
    step(en, clr, j, k, flop_q, !flop_q);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    model_reset();
    check_zero("rst");
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b0; CLR = 1'b0; J = 1'b0; K = 1'b0; Q = 1'b0; Q_BAR = 1'b1;
    do_reset();

    // 1: correct flop, JK = 01,10,00,11,11,01
    good(1, 0, 0, 1);
    chk("t1_synced_after_edge1", 32'(synced8), 32'd1);
    good(1, 0, 1, 0);
    good(1, 0, 0, 0);
    good(1, 0, 1, 1);
    good(1, 0, 1, 1);
    good(1, 0, 0, 1);
    chk("t1_expq_final", 32'(expq8), 32'd0);
    chk("t1_trans", 32'(trans8), 32'd4);
    chk("t1_err", 32'(err8), 32'd0);

    // 2: Q stuck at 0, JK = 01,10,10,00
    do_reset();
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 1, 0, 0, 1);
    chk("t2_no_mis_e2", 32'(mis8), 32'd0);
    step(1, 0, 1, 0, 0, 1);
    chk("t2_mis_e3", 32'(mis8), 32'd1);
    step(1, 0, 0, 0, 0, 1);
    chk("t2_mis_e4", 32'(mis8), 32'd1);
    step(1, 0, 0, 0, 0, 1);
    chk("t2_no_mis_e5", 32'(mis8), 32'd0);
    chk("t2_err", 32'(err8), 32'd2);
    chk("t2_sticky", 32'(sticky8), 32'd1);

    // 3: complement fault in UNSYNC with JK=00 for 6 edges
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 1'(i % 2), 1'(i % 2));
      chk("t3_mis", 32'(mis2), 32'd1);
    end
    chk("t3_err2_sat", 32'(err2), 32'd3);
    chk("t3_synced", 32'(synced2), 32'd0);

    // 4: SYNC with EXP_Q=1, EN low for 2 edges, then 11, then re-sync
    do_reset();
    good(1, 0, 1, 0);
    chk("t4_expq1", 32'(expq8), 32'd1);
    good(0, 0, 1, 1);
    chk("t4_gap_synced", 32'(synced8), 32'd0);
    step(0, 0, 0, 1, !flop_q, !flop_q);
    chk("t4_gap_mis", 32'(mis8), 32'd0);
    good(1, 0, 1, 1);
    chk("t4_still_unsync", 32'(synced8), 32'd0);
    good(1, 0, 0, 1);
    chk("t4_resync", 32'(synced8), 32'd1);

    // 5: mismatching edge together with CLR
    step(1, 1, 0, 0, !flop_q, flop_q);
    chk("t5_mis", 32'(mis8), 32'd1);
    chk("t5_err", 32'(err8), 32'd0);
    chk("t5_sticky", 32'(sticky8), 32'd0);
    good(1, 0, 0, 0);

    // 6: reset mid-cycle while SYNC with ERR_COUNT=5
    good(1, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, flop_q, flop_q);
    chk("t6_err5", 32'(err8), 32'd5);
    chk("t6_sync", 32'(synced8), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    model_reset();
    check_zero("t6_async");
    @(negedge CLK);
    check_zero("t6_held");
    RST_N = 1'b1;
    good(1, 0, 0, 0);
    chk("t6_first_no_cmp", 32'(mis8), 32'd0);

    // Randomized phase against the reference model
    for (int i = 0; i < 400; i++) begin
      bit en, clr, j, k, q, qb;
      int mode;
      en   = ($urandom_range(0, 9) != 0);
      clr  = ($urandom_range(0, 24) == 0);
      j    = 1'($urandom);
      k    = 1'($urandom);
      mode = $urandom_range(0, 9);
      if (mode < 6) begin
        q = flop_q; qb = !flop_q;
      end else if (mode < 8) begin
        q = 1'($urandom); qb = !q;
      end else if (mode == 8) begin
        q = 1'($urandom); qb = q;
      end else begin
        q = 1'($urandom); qb = 1'($urandom);
      end
      step(en, clr, j, k, q, qb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
